// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter and its picker.
package mem_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Index width that stays legal for any requester count.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational requester picker: fixed lowest-index priority or round-robin after i_ptr.
module rr_picker
  import mem_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_rr_mode,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    if (i_rr_mode) begin
      // Walk from farthest to nearest so the port just after i_ptr overwrites last.
      for (int k = N; k >= 1; k--) begin
        if (i_valid[(int'(i_ptr) + k) % N]) begin
          o_any = 1'b1;
          o_idx = IDX_W'((int'(i_ptr) + k) % N);
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (i_valid[i]) begin
          o_any = 1'b1;
          o_idx = IDX_W'(i);
        end
      end
    end
    o_grant[o_idx] = o_any;
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-requester arbiter onto one synchronous RAM port with fixed-latency read routing.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int RR_MODE      = 0,
  localparam int BE_W        = DATA_W / 8,
  localparam int IDX_W       = idx_width(NUM_PORTS),
  localparam int CNT_W       = $clog2(READ_LATENCY) + 1
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [NUM_PORTS-1:0]             i_req_valid,
  output logic [NUM_PORTS-1:0]             o_req_ready,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] i_req_addr,
  input  logic [NUM_PORTS-1:0][BE_W-1:0]   i_req_we,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] i_req_wdata,
  output logic [NUM_PORTS-1:0]             o_resp_valid,
  output logic [DATA_W-1:0]                o_resp_rdata,
  output logic                             o_mem_en,
  output logic [BE_W-1:0]                  o_mem_we,
  output logic [ADDR_W-1:0]                o_mem_addr,
  output logic [DATA_W-1:0]                o_mem_wdata,
  input  logic [DATA_W-1:0]                i_mem_rdata
);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_ptr;

  logic [NUM_PORTS-1:0] w_pick_grant;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_any;
  logic                 w_last_cycle;
  logic                 w_grant_ok;
  logic                 w_gnt;
  logic                 w_gnt_read;
  logic                 w_resp;

  rr_picker #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_valid   (i_req_valid),
    .i_ptr     (r_ptr),
    .i_rr_mode (1'(RR_MODE)),
    .o_grant   (w_pick_grant),
    .o_idx     (w_pick_idx),
    .o_any     (w_pick_any)
  );

  // The response cycle of a read doubles as the next grant slot.
  assign w_last_cycle = (r_state == RD_WAIT) && (r_cnt == '0);
  assign w_grant_ok   = !i_reset && ((r_state == IDLE) || w_last_cycle);
  assign w_gnt        = w_grant_ok && w_pick_any;
  assign w_gnt_read   = w_gnt && (i_req_we[w_pick_idx] == '0);
  assign w_resp       = !i_reset && w_last_cycle;

  always_comb begin
    o_req_ready  = w_gnt ? w_pick_grant : '0;
    o_mem_en     = w_gnt;
    o_mem_we     = w_gnt ? i_req_we[w_pick_idx]    : '0;
    o_mem_addr   = w_gnt ? i_req_addr[w_pick_idx]  : '0;
    o_mem_wdata  = w_gnt ? i_req_wdata[w_pick_idx] : '0;
    o_resp_valid = '0;
    o_resp_valid[r_owner] = w_resp;
    o_resp_rdata = w_resp ? i_mem_rdata : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_owner <= '0;
      r_ptr   <= IDX_W'(NUM_PORTS - 1);
    end else begin
      if (w_gnt) r_ptr <= w_pick_idx;
      if (w_grant_ok) begin
        if (w_gnt_read) begin
          r_state <= RD_WAIT;
          r_cnt   <= CNT_W'(READ_LATENCY - 1);
          r_owner <= w_pick_idx;
        end else begin
          r_state <= IDLE;
        end
      end else if (r_state == RD_WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin L=1, fixed-priority L=1 and round-robin L=3 arbiters share stimulus.
module tb_mem_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_addr;
  logic [1:0][3:0]  req_we;
  logic [1:0][31:0] req_wdata;
  logic [31:0]      mem_rdata;

  logic [1:0] rr_ready, rr_resp, fx_ready, fx_resp, l3_ready, l3_resp;
  logic [31:0] rr_rdata, fx_rdata, l3_rdata;
  logic        rr_en, fx_en, l3_en;
  logic [3:0]  rr_we, fx_we, l3_we;
  logic [31:0] rr_addr, fx_addr, l3_addr, rr_wdata, fx_wdata, l3_wdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_PORTS(2), .READ_LATENCY(1), .RR_MODE(1)) dut_rr (
    .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(rr_ready),
    .i_req_addr(req_addr), .i_req_we(req_we), .i_req_wdata(req_wdata),
    .o_resp_valid(rr_resp), .o_resp_rdata(rr_rdata), .o_mem_en(rr_en), .o_mem_we(rr_we),
    .o_mem_addr(rr_addr), .o_mem_wdata(rr_wdata), .i_mem_rdata(mem_rdata));

  mem_arbiter #(.NUM_PORTS(2), .READ_LATENCY(1), .RR_MODE(0)) dut_fx (
    .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(fx_ready),
    .i_req_addr(req_addr), .i_req_we(req_we), .i_req_wdata(req_wdata),
    .o_resp_valid(fx_resp), .o_resp_rdata(fx_rdata), .o_mem_en(fx_en), .o_mem_we(fx_we),
    .o_mem_addr(fx_addr), .o_mem_wdata(fx_wdata), .i_mem_rdata(mem_rdata));

  mem_arbiter #(.NUM_PORTS(2), .READ_LATENCY(3), .RR_MODE(1)) dut_l3 (
    .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(l3_ready),
    .i_req_addr(req_addr), .i_req_we(req_we), .i_req_wdata(req_wdata),
    .o_resp_valid(l3_resp), .o_resp_rdata(l3_rdata), .o_mem_en(l3_en), .o_mem_we(l3_we),
    .o_mem_addr(l3_addr), .o_mem_wdata(l3_wdata), .i_mem_rdata(mem_rdata));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b11;
    req_addr  = '0;
    req_we    = '0;
    req_wdata = '0;
    mem_rdata = 32'hCAFE_F00D;
    req_addr[0] = 32'h40;
    req_addr[1] = 32'h100;

    // Reset with both ports requesting: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("rst_rr_ready", rr_ready, 2'b00);
      chk("rst_rr_en", rr_en, 1'b0);
      chk("rst_rr_addr", rr_addr, 32'h0);
      chk("rst_l3_ready", l3_ready, 2'b00);
      chk("rst_fx_resp", fx_resp, 2'b00);
      cyc();
    end

    // Release: port 0 first; then continuous contention.
    reset = 1'b0;
    #1;
    chk("c0_rr_ready", rr_ready, 2'b01);
    chk("c0_rr_addr", rr_addr, 32'h40);
    chk("c0_fx_ready", fx_ready, 2'b01);
    chk("c0_l3_ready", l3_ready, 2'b01);
    cyc();
    chk("c1_rr_ready", rr_ready, 2'b10);
    chk("c1_rr_addr", rr_addr, 32'h100);
    chk("c1_rr_resp", rr_resp, 2'b01);
    chk("c1_rr_rdata", rr_rdata, 32'hCAFE_F00D);
    chk("c1_fx_ready", fx_ready, 2'b01);
    chk("c1_l3_ready", l3_ready, 2'b00);
    chk("c1_l3_resp", l3_resp, 2'b00);
    cyc();
    chk("c2_rr_ready", rr_ready, 2'b01);
    chk("c2_rr_resp", rr_resp, 2'b10);
    chk("c2_fx_ready", fx_ready, 2'b01);
    chk("c2_l3_ready", l3_ready, 2'b00);
    chk("c2_l3_en", l3_en, 1'b0);
    cyc();
    chk("c3_rr_ready", rr_ready, 2'b10);
    chk("c3_fx_ready", fx_ready, 2'b01);
    chk("c3_fx_resp", fx_resp, 2'b01);
    chk("c3_l3_ready", l3_ready, 2'b10);
    chk("c3_l3_resp", l3_resp, 2'b01);
    chk("c3_l3_rdata", l3_rdata, 32'hCAFE_F00D);
    cyc();

    // Single read from port 1.
    reset = 1'b1;
    req_valid = 2'b10;
    mem_rdata = 32'hDEAD_BEEF;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rd_ready", rr_ready, 2'b10);
    chk("rd_en", rr_en, 1'b1);
    chk("rd_addr", rr_addr, 32'h100);
    chk("rd_resp_T", rr_resp, 2'b00);
    chk("rd_fx_ready", fx_ready, 2'b10);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("rd_resp", rr_resp, 2'b10);
    chk("rd_rdata", rr_rdata, 32'hDEAD_BEEF);
    chk("rd_idle_en", rr_en, 1'b0);
    chk("rd_idle_addr", rr_addr, 32'h0);
    cyc();

    // Partial write from port 0, then read from port 1.
    req_valid    = 2'b01;
    req_addr[0]  = 32'h20;
    req_we[0]    = 4'b0011;
    req_wdata[0] = 32'h0000_ABCD;
    #1;
    chk("wr_ready", rr_ready, 2'b01);
    chk("wr_we", rr_we, 4'b0011);
    chk("wr_addr", rr_addr, 32'h20);
    chk("wr_wdata", rr_wdata, 32'h0000_ABCD);
    cyc();
    req_valid = 2'b10;
    req_we[0] = 4'b0000;
    #1;
    chk("wr_noresp", rr_resp, 2'b00);
    chk("wr_rd_ready", rr_ready, 2'b10);
    chk("wr_rd_we", rr_we, 4'b0000);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("wr_rd_resp", rr_resp, 2'b10);
    cyc();

    // L=3 read interrupted by reset: response is lost, pointer restarts.
    reset = 1'b1;
    req_valid = 2'b01;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("abort_l3_ready", l3_ready, 2'b01);
    cyc();
    reset = 1'b1;
    #1;
    chk("abort_rst_resp", l3_resp, 2'b00);
    chk("abort_rst_en", l3_en, 1'b0);
    cyc();
    reset = 1'b0;
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("abort_noresp", l3_resp, 2'b00);
      cyc();
    end
    req_valid = 2'b11;
    #1;
    chk("abort_l3_restart", l3_ready, 2'b01);
    chk("abort_rr_restart", rr_ready, 2'b01);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
